// File: rtl/pipeline_stats_monitor_pkg.sv
// Shared MIPS-lite definitions for the retire-side statistics monitor:
// opcodes, instruction classes, counter index map and monitor states.
package mips_lite_pkg;

  localparam int OPC_W_DEF = 6;
  localparam int NUM_STATS = 9;

  localparam int STAT_CYCLES  = 0;
  localparam int STAT_TOTAL   = 1;
  localparam int STAT_ARITH   = 2;
  localparam int STAT_LOGIC   = 3;
  localparam int STAT_MEM     = 4;
  localparam int STAT_CONTROL = 5;
  localparam int STAT_TAKEN   = 6;
  localparam int STAT_STALLS  = 7;
  localparam int STAT_RAW     = 8;

  typedef enum logic [OPC_W_DEF-1:0] {
    ADD = 6'h00, ADDI, SUB, SUBI, MUL, MULI,
    OR, ORI, AND, ANDI, XOR, XORI,
    LDW, STW,
    BZ, BEQ, JR, HALT
  } opcode_e;

  typedef enum logic [2:0] {
    ARITH   = 3'd0,
    LOGIC   = 3'd1,
    MEM     = 3'd2,
    CONTROL = 3'd3,
    OTHER   = 3'd4
  } instr_class_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } monitor_state_e;

  function automatic instr_class_e classify(input logic [OPC_W_DEF-1:0] op);
    instr_class_e cls;
    if (op <= 6'h05) begin
      cls = ARITH;
    end else if (op <= 6'h0B) begin
      cls = LOGIC;
    end else if (op <= 6'h0D) begin
      cls = MEM;
    end else if (op <= 6'h11) begin
      cls = CONTROL;
    end else begin
      cls = OTHER;
    end
    return cls;
  endfunction

  // HALT is a control opcode but never redirects the PC.
  function automatic logic is_branch(input logic [OPC_W_DEF-1:0] op);
    return (op == BZ) || (op == BEQ) || (op == JR);
  endfunction

endpackage

// File: rtl/pipeline_stats_monitor_if.sv
// Retire/statistics bus between a MIPS-lite core wrapper and the monitor.
interface pipeline_stats_monitor_if #(
  parameter int CNT_W = 32,
  parameter int OPC_W = 6
);
  logic             start;
  logic             retire_valid;
  logic [OPC_W-1:0] retire_opcode;
  logic             branch_taken;
  logic             stall;
  logic             raw_hazard;
  logic             stat_rd;
  logic [3:0]       stat_sel;
  logic             stat_vld;
  logic [CNT_W-1:0] stat_data;
  logic             running;
  logic             done;
  logic             ovf;

  modport master (
    output start, retire_valid, retire_opcode, branch_taken, stall, raw_hazard,
    output stat_rd, stat_sel,
    input  stat_vld, stat_data, running, done, ovf
  );

  modport slave (
    input  start, retire_valid, retire_opcode, branch_taken, stall, raw_hazard,
    input  stat_rd, stat_sel,
    output stat_vld, stat_data, running, done, ovf
  );
endinterface

// File: rtl/pipeline_stats_monitor_stats_counter.sv
// Single statistics counter. Wraps by default; saturates at all-ones when
// STATS_SATURATE_EN is defined.
module stats_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] value,
  output logic             at_max
);

  logic [CNT_W-1:0] value_q, value_d;

  always_comb begin
    value_d = value_q;
    if (inc) begin
`ifdef STATS_SATURATE_EN
      if (at_max) begin
        value_d = value_q;
      end else begin
        value_d = value_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
`else
      value_d = value_q + {{(CNT_W-1){1'b0}}, 1'b1};
`endif
    end else begin
      value_d = value_q;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value  = value_q;
  assign at_max = &value_q;

endmodule

// File: rtl/pipeline_stats_monitor.sv
// Retire-side statistics monitor: IDLE/RUN/DONE control, nine event counters
// and a registered read port. STATS_SATURATE_EN selects saturating counters + ovf.
module pipeline_stats_monitor
  import mips_lite_pkg::*;
#(
  parameter int CNT_W = 32,
  parameter int OPC_W = 6
) (
  input logic                     clock,
  input logic                     reset,
  pipeline_stats_monitor_if.slave bus
);

  monitor_state_e   state_q, state_d;
  logic             running_q, done_q;
  logic             stat_vld_q;
  logic [CNT_W-1:0] stat_data_q, stat_data_d;

  logic [OPC_W-1:0]     op_s;
  instr_class_e         cls_s;
  logic                 run_s, halt_s;
  logic [NUM_STATS-1:0] inc_s, at_max_s;
  logic [CNT_W-1:0]     cnt_s [NUM_STATS];

  assign op_s   = bus.retire_opcode;
  assign cls_s  = classify(op_s);
  assign run_s  = (state_q == ST_RUN);
  assign halt_s = run_s & bus.retire_valid & (op_s == HALT);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) state_d = ST_RUN;
        else           state_d = ST_IDLE;
      end
      ST_RUN: begin
        if (halt_s) state_d = ST_DONE;
        else        state_d = ST_RUN;
      end
      ST_DONE: state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end

  // The HALT cycle is still RUN, so it is counted in full before DONE.
  always_comb begin
    inc_s = '0;
    if (run_s) begin
      inc_s[STAT_CYCLES]  = 1'b1;
      inc_s[STAT_TOTAL]   = bus.retire_valid;
      inc_s[STAT_ARITH]   = bus.retire_valid & (cls_s == ARITH);
      inc_s[STAT_LOGIC]   = bus.retire_valid & (cls_s == LOGIC);
      inc_s[STAT_MEM]     = bus.retire_valid & (cls_s == MEM);
      inc_s[STAT_CONTROL] = bus.retire_valid & (cls_s == CONTROL);
      inc_s[STAT_TAKEN]   = bus.retire_valid & bus.branch_taken & is_branch(op_s);
      inc_s[STAT_STALLS]  = bus.stall;
      inc_s[STAT_RAW]     = bus.raw_hazard;
    end else begin
      inc_s = '0;
    end
  end

  for (genvar gi = 0; gi < NUM_STATS; gi++) begin : g_cnt
    stats_counter #(.CNT_W(CNT_W)) u_cnt (
      .clock  (clock),
      .reset  (reset),
      .inc    (inc_s[gi]),
      .value  (cnt_s[gi]),
      .at_max (at_max_s[gi])
    );
  end

  // Counters are sampled before this edge's increment lands.
  always_comb begin
    stat_data_d = '0;
    if (bus.stat_rd && (bus.stat_sel < 4'd9)) begin
      stat_data_d = cnt_s[bus.stat_sel];
    end else begin
      stat_data_d = '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      running_q   <= 1'b0;
      done_q      <= 1'b0;
      stat_vld_q  <= 1'b0;
      stat_data_q <= '0;
    end else begin
      state_q     <= state_d;
      running_q   <= (state_d == ST_RUN);
      done_q      <= (state_d == ST_DONE);
      stat_vld_q  <= bus.stat_rd;
      stat_data_q <= stat_data_d;
    end
  end

`ifdef STATS_SATURATE_EN
  logic ovf_q, ovf_d;

  assign ovf_d = ovf_q | (|(inc_s & at_max_s));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign bus.ovf = ovf_q;
`else
  logic unused_at_max_s;

  assign unused_at_max_s = |at_max_s;
  assign bus.ovf         = 1'b0;
`endif

  assign bus.running   = running_q;
  assign bus.done      = done_q;
  assign bus.stat_vld  = stat_vld_q;
  assign bus.stat_data = stat_data_q;

endmodule

// File: tb/tb_pipeline_stats_monitor.sv
// Self-checking bench for pipeline_stats_monitor: directed scenarios plus
// randomized runs against an unbounded-count reference model.
module tb_pipeline_stats_monitor;

`ifdef STATS_SATURATE_EN
  localparam int CNT_W = 4;
`else
  localparam int CNT_W = 8;
`endif
  localparam logic [63:0] MAXV = (64'd1 << CNT_W) - 64'd1;

  logic clock = 1'b0;
  logic reset = 1'b1;

  pipeline_stats_monitor_if #(.CNT_W(CNT_W), .OPC_W(6)) bus ();

  pipeline_stats_monitor #(.CNT_W(CNT_W), .OPC_W(6)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;

  // Model: true event counts (never wrapped) and state 0=idle 1=run 2=done.
  longint m_cnt [9];
  int     m_state = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] fold(input longint c);
`ifdef STATS_SATURATE_EN
    return (c > longint'(MAXV)) ? MAXV : 64'(c);
`else
    return 64'(c) & MAXV;
`endif
  endfunction

  function automatic logic [63:0] model_value(input int sel);
    if (sel > 8) return 64'd0;
    return fold(m_cnt[sel]);
  endfunction

  function automatic logic model_ovf();
`ifdef STATS_SATURATE_EN
    for (int i = 0; i < 9; i++) begin
      if (m_cnt[i] > longint'(MAXV)) return 1'b1;
    end
`endif
    return 1'b0;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 9; i++) m_cnt[i] = 0;
    m_state = 0;
  endtask

  task automatic set_idle();
    bus.start = 1'b0; bus.retire_valid = 1'b0; bus.retire_opcode = 6'h00;
    bus.branch_taken = 1'b0; bus.stall = 1'b0; bus.raw_hazard = 1'b0;
    bus.stat_rd = 1'b0; bus.stat_sel = 4'd0;
  endtask

  // One clock: predict from pre-edge inputs, then compare all outputs after the edge.
  task automatic step();
    logic [63:0] exp_data;
    logic        exp_vld;
    int          op;
    exp_vld  = bus.stat_rd;
    exp_data = bus.stat_rd ? model_value(int'(bus.stat_sel)) : 64'd0;
    op = int'(bus.retire_opcode);
    if (m_state == 1) begin
      m_cnt[0]++;
      if (bus.retire_valid) begin
        m_cnt[1]++;
        if (op <= 5) m_cnt[2]++;
        else if (op <= 11) m_cnt[3]++;
        else if (op <= 13) m_cnt[4]++;
        else if (op <= 17) m_cnt[5]++;
        if (bus.branch_taken && op >= 14 && op <= 16) m_cnt[6]++;
      end
      if (bus.stall) m_cnt[7]++;
      if (bus.raw_hazard) m_cnt[8]++;
    end
    if (m_state == 0 && bus.start) m_state = 1;
    else if (m_state == 1 && bus.retire_valid && op == 17) m_state = 2;
    @(posedge clock);
    #1;
    check("running", bus.running, m_state == 1);
    check("done", bus.done, m_state == 2);
    check("ovf", bus.ovf, model_ovf());
    check("stat_vld", bus.stat_vld, exp_vld);
    check("stat_data", bus.stat_data, exp_data);
    @(negedge clock);
  endtask

  task automatic read_lit(input int sel, input longint lit);
    bus.stat_rd = 1'b1;
    bus.stat_sel = sel[3:0];
    step();
    check("lit_vld", bus.stat_vld, 1'b1);
    check($sformatf("lit_sel%0d", sel), bus.stat_data, 64'(lit));
    bus.stat_rd = 1'b0;
  endtask

  task automatic retire(input int op, input logic bt);
    bus.retire_valid = 1'b1;
    bus.retire_opcode = op[5:0];
    bus.branch_taken = bt;
    step();
    bus.retire_valid = 1'b0;
    bus.branch_taken = 1'b0;
  endtask

  // Asserted away from any edge so the clear must be asynchronous.
  task automatic apply_reset();
    @(negedge clock);
    #2 reset = 1'b1;
    #1;
    model_clear();
    check("rst_running", bus.running, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_ovf", bus.ovf, 1'b0);
    check("rst_vld", bus.stat_vld, 1'b0);
    check("rst_data", bus.stat_data, 64'd0);
    set_idle();
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic randomize_inputs(input bit allow_start);
    int op;
    op = int'($urandom_range(0, 63));
    if (op == 17 && $urandom_range(0, 199) != 0) op = 63;
    bus.start = allow_start && ($urandom_range(0, 7) == 0);
    bus.retire_valid = ($urandom_range(0, 3) != 0);
    bus.retire_opcode = op[5:0];
    bus.branch_taken = $urandom_range(0, 1);
    bus.stall = ($urandom_range(0, 3) == 0);
    bus.raw_hazard = ($urandom_range(0, 4) == 0);
    bus.stat_rd = $urandom_range(0, 1);
    bus.stat_sel = 4'($urandom_range(0, 15));
  endtask

  initial begin
    longint exp_prog [9] = '{9, 9, 3, 1, 2, 3, 1, 0, 0};
    int     n_stall;
    longint exp_stall;

    set_idle();
    model_clear();
    #2;
    check("init_running", bus.running, 1'b0);
    check("init_vld", bus.stat_vld, 1'b0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;

    // Idle: retires without start count nothing.
    for (int i = 0; i < 20; i++) retire(6'h00, 1'b0);
    for (int s = 0; s < 9; s++) read_lit(s, 0);
    check("idle_running", bus.running, 1'b0);

    // Program: the ADD coincident with start is not counted.
    bus.start = 1'b1;
    retire(6'h00, 1'b0);
    bus.start = 1'b0;
    check("run_entered", bus.running, 1'b1);
    retire(6'h00, 1'b0); retire(6'h01, 1'b0); retire(6'h02, 1'b0);
    retire(6'h06, 1'b0); retire(6'h0C, 1'b0); retire(6'h0D, 1'b0);
    retire(6'h0F, 1'b1); retire(6'h0E, 1'b0);
    check("done_before_halt", bus.done, 1'b0);
    retire(6'h11, 1'b1);
    check("done_after_halt", bus.done, 1'b1);
    for (int s = 0; s < 9; s++) read_lit(s, exp_prog[s]);

    // DONE is terminal: nothing counts, start ignored.
    for (int i = 0; i < 10; i++) begin
      bus.start = 1'b1; bus.stall = 1'b1; bus.raw_hazard = 1'b1;
      retire(int'($urandom_range(0, 17)), 1'b1);
    end
    set_idle();
    check("done_sticky", bus.done, 1'b1);
    for (int s = 0; s < 9; s++) read_lit(s, exp_prog[s]);

    // Stalls and RAW pulses, one overlapping a stall together with a retire.
    apply_reset();
    bus.start = 1'b1; step(); bus.start = 1'b0;
    bus.stall = 1'b1; step();
    bus.raw_hazard = 1'b1; retire(6'h00, 1'b0); bus.raw_hazard = 1'b0;
    step(); step();
    bus.stall = 1'b0; bus.raw_hazard = 1'b1; step(); bus.raw_hazard = 1'b0;
    read_lit(7, 4);
    read_lit(8, 2);
    read_lit(1, 1);
    read_lit(12, 0);
    read_lit(0, 9);
    read_lit(0, 10);

    // Mid-run reset after five retires.
    apply_reset();
    bus.start = 1'b1; step(); bus.start = 1'b0;
    for (int i = 0; i < 5; i++) retire(6'h04, 1'b0);
    apply_reset();
    check("midrst_running", bus.running, 1'b0);
    for (int s = 0; s < 9; s++) read_lit(s, 0);

    // Width boundary: wrap by default, saturate with ovf otherwise.
`ifdef STATS_SATURATE_EN
    n_stall = 17; exp_stall = 15;
`else
    n_stall = 258; exp_stall = 2;
`endif
    apply_reset();
    bus.start = 1'b1; step(); bus.start = 1'b0;
    bus.stall = 1'b1;
    for (int i = 0; i < n_stall; i++) step();
    bus.stall = 1'b0;
    read_lit(7, exp_stall);
`ifdef STATS_SATURATE_EN
    check("sat_ovf", bus.ovf, 1'b1);
`else
    check("wrap_ovf", bus.ovf, 1'b0);
`endif

    // Randomized runs.
    for (int seg = 0; seg < 3; seg++) begin
      apply_reset();
      for (int i = 0; i < 5; i++) begin randomize_inputs(1'b0); step(); end
      set_idle(); bus.start = 1'b1; step();
      for (int i = 0; i < 500; i++) begin randomize_inputs(1'b1); step(); end
      set_idle(); retire(6'h11, 1'b0);
      check("seg_done", bus.done, 1'b1);
      for (int i = 0; i < 20; i++) begin randomize_inputs(1'b1); step(); end
      set_idle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pipeline_stats_monitor.md
Name: pipeline_stats_monitor

Overview:
- Retire-side statistics collector for the MIPS-lite cores: no-pipeline, pipeline without forwarding and pipeline with forwarding.
- Sits between each core's writeback/retire point and the top-level bench.
- Classifies every retired instruction, counts cycles, stalls and RAW hazards, and raises a sticky done when HALT retires.
- The bench reads the counters through a registered read port and does no arithmetic fix-ups (HALT is already in the control count).

Parameters:
- CNT_W, 32: width of every statistics counter and of stat_data.
- OPC_W, 6: instruction opcode width.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; arms counting.
- retire_valid  in  1  one instruction retires this cycle.
- retire_opcode  in  OPC_W  opcode of the retiring instruction.
- branch_taken  in  1  qualified by retire_valid; the retiring BZ/BEQ/JR redirected the PC.
- stall  in  1  pipeline held this cycle (one count per cycle asserted).
- raw_hazard  in  1  one-cycle pulse per detected RAW hazard event.
- stat_rd  in  1  read request.
- stat_sel  in  4  counter index.
- stat_vld  out  1  read data valid.
- stat_data  out  CNT_W  selected counter value.
- running  out  1  state is RUN.
- done  out  1  sticky; HALT has retired.
- ovf  out  1  sticky counter overflow flag; only functional with the optional feature.

Behaviour:
- Reset is asynchronous, active-high. While reset is asserted and after it is released:
  - all counters are 0;
  - state is IDLE;
  - running, done, ovf, stat_vld are 0;
  - stat_data is 0.
- Reset asserted mid-run clears everything immediately, with no drain.
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN on start. Nothing counts in IDLE, including a retire coincident with start.
  - RUN -> DONE on the cycle retire_valid=1 and retire_opcode=HALT. That cycle is still counted in full.
  - DONE is terminal until reset. start is ignored in RUN and DONE.
- Counters, all updated only in RUN:
  - cycles: +1 every RUN cycle.
  - total: +1 per retire_valid.
  - arith: +1 for opcodes 0x00–0x05 (ADD, ADDI, SUB, SUBI, MUL, MULI).
  - logic: +1 for 0x06–0x0B (OR, ORI, AND, ANDI, XOR, XORI).
  - mem: +1 for 0x0C–0x0D (LDW, STW).
  - control: +1 for 0x0E–0x11 (BZ, BEQ, JR, HALT). HALT is counted here.
  - taken: +1 when retire_valid, branch_taken and the opcode is BZ, BEQ or JR. branch_taken on any other opcode is ignored.
  - stalls: +1 per cycle stall=1.
  - raw: +1 per cycle raw_hazard=1.
- Opcodes 0x12–0x3F count in total only.
- Independent events in one cycle all count. Example: retire, stall and raw_hazard together give total+1, stalls+1, raw+1.
- Read port:
  - stat_rd sampled at edge N gives stat_vld=1 and stat_data at edge N+1, each for one cycle.
  - Index map: 0 cycles, 1 total, 2 arith, 3 logic, 4 mem, 5 control, 6 taken, 7 stalls, 8 raw. Index 9–15 returns 0 with stat_vld=1.
  - Reads are legal in any state and are back-to-back capable.
  - A read coinciding with an increment returns the pre-increment value.
- Width rule: counters wrap modulo 2^CNT_W (without the optional feature).

Optional Feature:
- Macro: STATS_SATURATE_EN.
- Defined:
  - counters saturate at 2^CNT_W−1;
  - any increment attempt while a counter is at max sets ovf, which is sticky until reset.
- Undefined:
  - counters wrap;
  - ovf is tied 0.

Decomposition:
- Package mips_lite_pkg:
  - opcode enum (ADD..HALT, 6-bit);
  - instr_class_e enum {ARITH, LOGIC, MEM, CONTROL, OTHER};
  - classify() function;
  - stat index localparams STAT_CYCLES..STAT_RAW;
  - monitor state enum.
- Sub-module stats_counter:
  - inputs clock, reset, inc;
  - outputs value, at_max;
  - saturation behaviour under STATS_SATURATE_EN;
  - instantiated 9 times.

Test Plan:
- Reset then idle: no start, 20 retires of ADD -> all counters 0, running=0.
- start, retire ADD, ADDI, SUB, OR, LDW, STW, BEQ(taken), BZ(not taken), HALT, one per cycle -> cycles=9, total=9, arith=3, logic=1, mem=2, control=3, taken=1, done=1 at 10th edge after start.
- In RUN: stall high 4 cycles, raw_hazard pulsed twice, one overlapping a stall -> stalls=4, raw=2. A retire in the overlap cycle also counts.
- Post-DONE: drive retires, stall, start for 10 cycles -> all counters unchanged, done stays 1.
- Read port: stat_rd with sel=1 then sel=12 on consecutive cycles -> stat_vld high for two cycles, stat_data = total, then 0. A read on an increment cycle returns the old value.
- Reset mid-RUN after 5 retires -> counters 0, state IDLE, done=0 asynchronously. With STATS_SATURATE_EN and CNT_W=4: 17 stall cycles -> stalls=15, ovf=1.
